// File: rtl/fpmul_cu.sv
// Control unit sequencing the single-precision FP multiplier datapath.
// Optional `FPMUL_CU_DBG_EN exposes the state register on port cs.
module fpmul_cu (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       Op_NaN,
    input  logic       Op_Inf,
    input  logic       Op_Zero,
    input  logic       Dnf,
    input  logic       MPH23,
    input  logic       Round,
    input  logic       Carry,
    input  logic       UFlow,
    input  logic       OFlow,
    output logic       SA_LD,
    output logic       EA_LD,
    output logic       MA_LD,
    output logic       SB_LD,
    output logic       EB_LD,
    output logic       MB_LD,
    output logic       SP_LD,
    output logic       EP_LD,
    output logic       EP_RST,
    output logic       EP_SET,
    output logic [1:0] EP_SEL,
    output logic       MPH_LD,
    output logic       MPH_RST,
    output logic       MPH_SET,
    output logic [2:0] MPH_SEL,
    output logic       MPL_LD,
    output logic       MPL_SEL,
    output logic       UF_RST,
    output logic       UF_LD,
    output logic       OF_RST,
    output logic       OF_LD,
    output logic       P_RST,
    output logic       P_LD,
    output logic       Done
`ifdef FPMUL_CU_DBG_EN
    ,
    output logic [3:0] cs
`endif
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_WAIT  = 4'd1,
        S_CHECK = 4'd2,
        S_BIAS  = 4'd3,
        S_NORM  = 4'd4,
        S_ROUND = 4'd5,
        S_EXP   = 4'd6,
        S_OUT   = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

`ifdef FPMUL_CU_DBG_EN
    assign cs = r_state;
`endif

    // Outputs are forced low while rst is held so no strobe leaks out.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        SP_LD   = 1'b0;
        EP_LD   = 1'b0;
        EP_RST  = 1'b0;
        EP_SET  = 1'b0;
        EP_SEL  = 2'b00;
        MPH_LD  = 1'b0;
        MPH_RST = 1'b0;
        MPH_SET = 1'b0;
        MPH_SEL = 3'b000;
        MPL_LD  = 1'b0;
        MPL_SEL = 1'b0;
        UF_LD   = 1'b0;
        OF_LD   = 1'b0;
        P_LD    = 1'b0;
        Done    = 1'b0;
        if (!rst) begin
            unique case (r_state)
                S_IDLE: begin
                    if (go) begin
                        w_start = 1'b1;
                        w_next  = S_WAIT;
                    end
                end
                S_WAIT: w_next = S_CHECK;
                S_CHECK: begin
                    SP_LD = 1'b1;
                    if (Op_NaN) begin
                        EP_SET  = 1'b1;
                        MPH_SET = 1'b1;
                        w_next  = S_OUT;
                    end else if (Op_Inf) begin
                        EP_SET  = 1'b1;
                        MPH_RST = 1'b1;
                        w_next  = S_OUT;
                    end else if (Op_Zero || Dnf) begin
                        EP_RST  = 1'b1;
                        MPH_RST = 1'b1;
                        w_next  = S_OUT;
                    end else begin
                        EP_LD  = 1'b1;
                        MPH_LD = 1'b1;
                        MPL_LD = 1'b1;
                        w_next = S_BIAS;
                    end
                end
                S_BIAS: begin
                    EP_LD  = 1'b1;
                    EP_SEL = 2'b10;
                    w_next = S_NORM;
                end
                S_NORM: begin
                    if (MPH23) begin
                        EP_LD  = 1'b1;
                        EP_SEL = 2'b01;
                    end else begin
                        MPH_LD  = 1'b1;
                        MPH_SEL = 3'b001;
                        MPL_LD  = 1'b1;
                        MPL_SEL = 1'b1;
                    end
                    w_next = S_ROUND;
                end
                S_ROUND: begin
                    if (Round && Carry) begin
                        MPH_LD  = 1'b1;
                        MPH_SEL = 3'b100;
                        EP_LD   = 1'b1;
                        EP_SEL  = 2'b01;
                    end else if (Round) begin
                        MPH_LD  = 1'b1;
                        MPH_SEL = 3'b010;
                    end
                    w_next = S_EXP;
                end
                S_EXP: begin
                    if (UFlow) begin
                        UF_LD   = 1'b1;
                        EP_RST  = 1'b1;
                        MPH_RST = 1'b1;
                    end else if (OFlow) begin
                        OF_LD   = 1'b1;
                        EP_SET  = 1'b1;
                        MPH_RST = 1'b1;
                    end
                    w_next = S_OUT;
                end
                S_OUT: begin
                    P_LD   = 1'b1;
                    w_next = S_DONE;
                end
                S_DONE: begin
                    Done = 1'b1;
                    if (go) begin
                        w_start = 1'b1;
                        w_next  = S_WAIT;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    assign SA_LD  = w_start;
    assign EA_LD  = w_start;
    assign MA_LD  = w_start;
    assign SB_LD  = w_start;
    assign EB_LD  = w_start;
    assign MB_LD  = w_start;
    assign P_RST  = w_start;
    assign UF_RST = w_start;
    assign OF_RST = w_start;

endmodule

// File: tb/tb_fpmul_cu.sv
// Self-checking bench for fpmul_cu: per-cycle strobe checks
// against a transaction-level model with randomized status flags.
module tb_fpmul_cu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go = 1'b0;
    logic       Op_NaN = 1'b0, Op_Inf = 1'b0;
    logic       Op_Zero = 1'b0, Dnf = 1'b0;
    logic       MPH23 = 1'b0, Round = 1'b0, Carry = 1'b0;
    logic       UFlow = 1'b0, OFlow = 1'b0;
    logic       SA_LD, EA_LD, MA_LD, SB_LD, EB_LD, MB_LD, SP_LD;
    logic       EP_LD, EP_RST, EP_SET;
    logic [1:0] EP_SEL;
    logic       MPH_LD, MPH_RST, MPH_SET;
    logic [2:0] MPH_SEL;
    logic       MPL_LD, MPL_SEL;
    logic       UF_RST, UF_LD, OF_RST, OF_LD, P_RST, P_LD, Done;
`ifdef FPMUL_CU_DBG_EN
    logic [3:0] cs;
`endif

    typedef struct packed {
        logic       sa, ea, ma, sb, eb, mb;
        logic       sp_ld, ep_ld, ep_rst, ep_set;
        logic [1:0] ep_sel;
        logic       mph_ld, mph_rst, mph_set;
        logic [2:0] mph_sel;
        logic       mpl_ld, mpl_sel;
        logic       uf_rst, uf_ld, of_rst, of_ld;
        logic       p_rst, p_ld, done;
    } ov_t;

    ov_t obs;
    int  checks = 0;
    int  errors = 0;

    assign obs = {SA_LD, EA_LD, MA_LD, SB_LD, EB_LD, MB_LD,
                  SP_LD, EP_LD, EP_RST, EP_SET, EP_SEL,
                  MPH_LD, MPH_RST, MPH_SET, MPH_SEL,
                  MPL_LD, MPL_SEL, UF_RST, UF_LD, OF_RST, OF_LD,
                  P_RST, P_LD, Done};

    always #5 clk = ~clk;

    fpmul_cu dut (
        .clk(clk), .rst(rst), .go(go),
        .Op_NaN(Op_NaN), .Op_Inf(Op_Inf),
        .Op_Zero(Op_Zero), .Dnf(Dnf),
        .MPH23(MPH23), .Round(Round), .Carry(Carry),
        .UFlow(UFlow), .OFlow(OFlow),
        .SA_LD(SA_LD), .EA_LD(EA_LD), .MA_LD(MA_LD),
        .SB_LD(SB_LD), .EB_LD(EB_LD), .MB_LD(MB_LD),
        .SP_LD(SP_LD), .EP_LD(EP_LD), .EP_RST(EP_RST),
        .EP_SET(EP_SET), .EP_SEL(EP_SEL),
        .MPH_LD(MPH_LD), .MPH_RST(MPH_RST), .MPH_SET(MPH_SET),
        .MPH_SEL(MPH_SEL), .MPL_LD(MPL_LD), .MPL_SEL(MPL_SEL),
        .UF_RST(UF_RST), .UF_LD(UF_LD),
        .OF_RST(OF_RST), .OF_LD(OF_LD),
        .P_RST(P_RST), .P_LD(P_LD), .Done(Done)
`ifdef FPMUL_CU_DBG_EN
        , .cs(cs)
`endif
    );

    // New cycle: go plus fresh random product status.
    task automatic drive(input logic g);
        @(negedge clk);
        go = g;
        {MPH23, Round, Carry, UFlow, OFlow} = 5'($urandom);
    endtask

    task automatic chk(input ov_t e, input string tag);
        #1;
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    function automatic ov_t start_vec(input logic from_done);
        ov_t e;
        e = '0;
        {e.sa, e.ea, e.ma, e.sb, e.eb, e.mb} = 6'h3f;
        e.p_rst  = 1'b1;
        e.uf_rst = 1'b1;
        e.of_rst = 1'b1;
        e.done   = from_done;
        return e;
    endfunction

    function automatic ov_t check_vec(input logic nan, inf, zero, dnf);
        ov_t e;
        e = '0;
        e.sp_ld = 1'b1;
        if (nan) begin
            e.ep_set  = 1'b1;
            e.mph_set = 1'b1;
        end else if (inf) begin
            e.ep_set  = 1'b1;
            e.mph_rst = 1'b1;
        end else if (zero || dnf) begin
            e.ep_rst  = 1'b1;
            e.mph_rst = 1'b1;
        end else begin
            e.ep_ld  = 1'b1;
            e.mph_ld = 1'b1;
            e.mpl_ld = 1'b1;
        end
        return e;
    endfunction

    // One multiply: go cycle, then every step until DONE, then hold.
    task automatic do_op(input logic from_done,
                         input logic nan, inf, zero, dnf,
                         input int hold);
        ov_t e;
        logic special;
        special = nan | inf | zero | dnf;
        drive(1'b1);
        chk(start_vec(from_done), "start");
        drive(1'($urandom));
        {Op_NaN, Op_Inf, Op_Zero, Dnf} = {nan, inf, zero, dnf};
        chk('0, "wait");
        drive(1'($urandom));
        chk(check_vec(nan, inf, zero, dnf), "check");
        if (!special) begin
            drive(1'($urandom));
            e = '0;
            e.ep_ld  = 1'b1;
            e.ep_sel = 2'b10;
            chk(e, "bias");
            drive(1'($urandom));
            e = '0;
            if (MPH23) begin
                e.ep_ld  = 1'b1;
                e.ep_sel = 2'b01;
            end else begin
                e.mph_ld  = 1'b1;
                e.mph_sel = 3'b001;
                e.mpl_ld  = 1'b1;
                e.mpl_sel = 1'b1;
            end
            chk(e, "norm");
            drive(1'($urandom));
            e = '0;
            if (Round) begin
                e.mph_ld  = 1'b1;
                e.mph_sel = Carry ? 3'b100 : 3'b010;
                e.ep_ld   = Carry;
                e.ep_sel  = Carry ? 2'b01 : 2'b00;
            end
            chk(e, "round");
            drive(1'($urandom));
            e = '0;
            e.uf_ld   = UFlow;
            e.of_ld   = !UFlow && OFlow;
            e.ep_rst  = UFlow;
            e.ep_set  = !UFlow && OFlow;
            e.mph_rst = UFlow || OFlow;
            chk(e, "exp");
        end
        drive(1'($urandom));
        e = '0;
        e.p_ld = 1'b1;
        chk(e, "out");
        for (int k = 0; k < hold; k++) begin
            drive(1'b0);
            e = '0;
            e.done = 1'b1;
            chk(e, "done_hold");
        end
    endtask

    initial begin
        ov_t e;
        logic n, i, z, d;
        // Reset state, with go both low and high.
        chk('0, "reset_go0");
        go = 1'b1;
        chk('0, "reset_go1");
        drive(1'b0);
        rst = 1'b0;
        chk('0, "idle");
        drive(1'b0);
        chk('0, "idle2");

        // Directed classes, including priority overlaps.
        do_op(1'b0, 0, 0, 0, 0, 2);
        do_op(1'b1, 1, 0, 0, 0, 1);
        do_op(1'b1, 0, 1, 0, 0, 0);
        do_op(1'b1, 0, 0, 1, 0, 0);
        do_op(1'b1, 0, 0, 0, 1, 1);
        do_op(1'b1, 1, 1, 1, 1, 1);
        do_op(1'b1, 0, 1, 1, 0, 1);
        do_op(1'b1, 0, 0, 1, 1, 0);

        // Random mix, biased towards the normal path.
        for (int k = 0; k < 60; k++) begin
            n = ($urandom_range(0, 7) == 0);
            i = ($urandom_range(0, 7) == 0);
            z = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 7) == 0);
            do_op(1'b1, n, i, z, d, $urandom_range(0, 2));
        end

        // Reset asserted mid-operation while in NORM.
        drive(1'b1);
        chk(start_vec(1'b1), "rs_start");
        drive(1'b0);
        {Op_NaN, Op_Inf, Op_Zero, Dnf} = 4'b0000;
        chk('0, "rs_wait");
        drive(1'b0);
        chk(check_vec(0, 0, 0, 0), "rs_check");
        drive(1'b0);
        e = '0;
        e.ep_ld  = 1'b1;
        e.ep_sel = 2'b10;
        chk(e, "rs_bias");
        drive(1'b1);
        MPH23 = 1'b1;
        e = '0;
        e.ep_ld  = 1'b1;
        e.ep_sel = 2'b01;
        chk(e, "rs_norm");
        #1;
        rst = 1'b1;
        chk('0, "rst_in_norm");
        drive(1'b1);
        chk('0, "rst_held");
        drive(1'b0);
        rst = 1'b0;
        chk('0, "rst_release");
        drive(1'b0);
        chk('0, "rst_idle");
        do_op(1'b0, 0, 0, 0, 0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
